// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI state encoding, mode encodings and word length
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    // Mode encoding is {CPOL, CPHA}, identical to the master
    localparam logic [1:0] MODE_POL_PHS_00 = 2'b00;
    localparam logic [1:0] MODE_POL_PHS_01 = 2'b01;
    localparam logic [1:0] MODE_POL_PHS_10 = 2'b10;
    localparam logic [1:0] MODE_POL_PHS_11 = 2'b11;

    localparam int WORD_LENGTH = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with registered rise/fall strobes
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // level is the delayed copy so it lines up with the registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
            fall  <= ~chain[STAGES-1] & prev;
        end
    end

    assign level = prev;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampling SPI target with TX holding register and RX word output
module spi_slave #(
    parameter int         WORD_LENGTH = spi_pkg::WORD_LENGTH,
    parameter logic [1:0] SPI_MODE    = spi_pkg::MODE_POL_PHS_00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   SCLK,
    input  logic                   MOSI,
    input  logic                   SSbar,
    output logic                   MISO,
    output logic                   MISO_OE,
    input  logic [WORD_LENGTH-1:0] TX_DATA,
    input  logic                   TX_VALID,
    output logic                   TX_READY,
    output logic [WORD_LENGTH-1:0] RX_DATA,
    output logic                   RX_VALID,
    output logic                   TX_UNDERRUN
);
    import spi_pkg::*;

    localparam logic CPOL = SPI_MODE[1];
    localparam logic CPHA = SPI_MODE[0];
    localparam int   CW   = $clog2(WORD_LENGTH + 1);

    state_t                 state, state_nxt;
    logic                   sclk_level, sclk_rise, sclk_fall;
    logic                   mosi_level, mosi_rise, mosi_fall;
    logic                   ss_level, ss_rise, ss_fall;
    logic                   unused_strobes;
    logic                   lead, trail, sample_edge, drive_edge;
    logic                   word_done, tx_load, wrapped, hold_full, miso_q;
    logic [CW-1:0]          bit_cnt;
    logic [WORD_LENGTH-1:0] hold, tx_shift, rx_shift;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(SCLK), .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(MOSI), .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .din(SSbar), .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    assign unused_strobes = sclk_level | mosi_rise | mosi_fall | ss_level;

    assign lead        = CPOL ? sclk_fall : sclk_rise;
    assign trail       = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail : lead;
    assign drive_edge  = CPHA ? lead : trail;
    assign word_done   = (state == SHIFT) && (bit_cnt == CW'(WORD_LENGTH));
    assign TX_READY    = !hold_full;
    assign tx_load     = TX_VALID && TX_READY;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (CPHA ? (wrapped && drive_edge) : word_done) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
        if (ss_rise) state_nxt = IDLE;
    end

    always_comb begin
        MISO_OE = (state != IDLE);
        MISO    = MISO_OE & miso_q;
    end

    // A drive edge with bit_cnt==0 is either the CPHA=1 first leading edge (MSB already
    // presented by LOAD) or the CPHA=0 trailing edge that closes the previous word.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold        <= '0;
            hold_full   <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            RX_DATA     <= '0;
            RX_VALID    <= 1'b0;
            TX_UNDERRUN <= 1'b0;
            bit_cnt     <= '0;
            wrapped     <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            RX_VALID    <= 1'b0;
            TX_UNDERRUN <= 1'b0;
            if (tx_load) begin
                hold      <= TX_DATA;
                hold_full <= 1'b1;
            end
            case (state)
                LOAD: begin
                    tx_shift <= hold_full ? hold : '0;
                    miso_q   <= hold_full & hold[WORD_LENGTH-1];
                    if (!hold_full) TX_UNDERRUN <= 1'b1;
                    if (!tx_load)   hold_full   <= 1'b0;
                    bit_cnt  <= '0;
                    wrapped  <= 1'b0;
                end
                SHIFT: begin
                    if (word_done) begin
                        RX_DATA  <= rx_shift;
                        RX_VALID <= 1'b1;
                        bit_cnt  <= '0;
                        wrapped  <= 1'b1;
                    end else if (sample_edge) begin
                        rx_shift <= {rx_shift[WORD_LENGTH-2:0], mosi_level};
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                    if (drive_edge && bit_cnt != '0) begin
                        tx_shift <= tx_shift << 1;
                        miso_q   <= tx_shift[WORD_LENGTH-2];
                    end
                end
                default: begin
                    bit_cnt <= '0;
                    wrapped <= 1'b0;
                end
            endcase
        end
    end

endmodule
